// File: rtl/uart_time_set_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_time_set_parser
// Description : Parses "Shh:mm:ss<CR|LF>" from the UART byte stream and hands
//               a validated BCD time to the RTC write port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_time_set_parser #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] set_hour,
    output logic [7:0] set_minute,
    output logic [7:0] set_second,
    output logic       set_req,
    input  logic       set_ack,
    output logic       cmd_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // Parse states are consecutive so a correct byte simply advances by one.
    localparam logic [3:0] c_IDLE = 4'd0;
    localparam logic [3:0] c_HT   = 4'd1;
    localparam logic [3:0] c_HU   = 4'd2;
    localparam logic [3:0] c_C1   = 4'd3;
    localparam logic [3:0] c_MT   = 4'd4;
    localparam logic [3:0] c_MU   = 4'd5;
    localparam logic [3:0] c_C2   = 4'd6;
    localparam logic [3:0] c_ST   = 4'd7;
    localparam logic [3:0] c_SU   = 4'd8;
    localparam logic [3:0] c_TERM = 4'd9;
    localparam logic [3:0] c_REQ  = 4'd10;

    localparam logic [1:0] c_E_FORMAT  = 2'd0;
    localparam logic [1:0] c_E_RANGE   = 2'd1;
    localparam logic [1:0] c_E_BUSY    = 2'd2;
    localparam logic [1:0] c_E_TIMEOUT = 2'd3;

    localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [3:0]  r_state;
    logic [23:0] r_shadow;
    logic [31:0] r_cnt;

    logic [3:0]  w_next;
    logic        w_err;
    logic [1:0]  w_code;
    logic        w_digit_we;
    logic        w_clr_shadow;
    logic        w_load;
    logic        w_byte_ok;
    logic        w_range_bad;
    logic        w_is_digit;
    logic        w_is_s;
    logic        w_parsing;
    logic        w_timeout;

    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_s     = (rx_data == 8'h53);
    assign w_parsing  = (r_state != c_IDLE) && (r_state != c_REQ);
    assign w_timeout  = w_parsing && !rx_valid && (r_cnt >= c_TO_LAST);

    // Byte acceptance and field range checks for the current parse state.
    always_comb begin
        w_byte_ok   = 1'b0;
        w_range_bad = 1'b0;
        case (r_state)
            c_HT: begin
                w_byte_ok   = w_is_digit;
                w_range_bad = rx_data[3:0] > 4'd2;
            end
            c_HU: begin
                w_byte_ok   = w_is_digit;
                w_range_bad = (r_shadow[23:20] == 4'd2) && (rx_data[3:0] > 4'd3);
            end
            c_MT, c_ST: begin
                w_byte_ok   = w_is_digit;
                w_range_bad = rx_data[3:0] > 4'd5;
            end
            c_MU, c_SU: w_byte_ok = w_is_digit;
            c_C1, c_C2: w_byte_ok = (rx_data == 8'h3A);
            c_TERM:     w_byte_ok = (rx_data == 8'h0D) || (rx_data == 8'h0A);
            default:    w_byte_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_err        = 1'b0;
        w_code       = c_E_FORMAT;
        w_digit_we   = 1'b0;
        w_clr_shadow = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (rx_valid && w_is_s) begin
                    w_next       = c_HT;
                    w_clr_shadow = 1'b1;
                end
            end
            c_REQ: begin
                if (rx_valid) begin
                    w_err  = 1'b1;
                    w_code = c_E_BUSY;
                end
                if (set_ack) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                if (rx_valid) begin
                    if (w_is_s) begin
                        w_next       = c_HT;
                        w_clr_shadow = 1'b1;
                    end else if (!w_byte_ok) begin
                        w_next = c_IDLE;
                        w_err  = 1'b1;
                        w_code = c_E_FORMAT;
                    end else if (w_range_bad) begin
                        w_next = c_IDLE;
                        w_err  = 1'b1;
                        w_code = c_E_RANGE;
                    end else begin
                        w_next     = r_state + 4'd1;
                        w_digit_we = 1'b1;
                        w_load     = (r_state == c_TERM);
                    end
                end else if (w_timeout) begin
                    w_next = c_IDLE;
                    w_err  = 1'b1;
                    w_code = c_E_TIMEOUT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_shadow   <= 24'h0;
            r_cnt      <= 32'd0;
            set_hour   <= 8'h00;
            set_minute <= 8'h00;
            set_second <= 8'h00;
            cmd_err    <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            r_state <= w_next;
            cmd_err <= w_err;
            if (w_err) begin
                err_code <= w_code;
            end
            if (rx_valid || !w_parsing) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_clr_shadow) begin
                r_shadow <= 24'h0;
            end else if (w_digit_we) begin
                case (r_state)
                    c_HT:    r_shadow[23:20] <= rx_data[3:0];
                    c_HU:    r_shadow[19:16] <= rx_data[3:0];
                    c_MT:    r_shadow[15:12] <= rx_data[3:0];
                    c_MU:    r_shadow[11:8]  <= rx_data[3:0];
                    c_ST:    r_shadow[7:4]   <= rx_data[3:0];
                    c_SU:    r_shadow[3:0]   <= rx_data[3:0];
                    default: r_shadow        <= r_shadow;
                endcase
            end
            if (w_load) begin
                set_hour   <= r_shadow[23:16];
                set_minute <= r_shadow[15:8];
                set_second <= r_shadow[7:0];
            end
        end
    end

    assign set_req = (r_state == c_REQ);
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire
